// File: rtl/mic_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module      : mic_regfile_mem
// Description : Mic-1 register file with integrated, handshaked memory
//               controller. Drives the B bus from one selected register,
//               loads any set of registers from the C bus, and runs an
//               independent data port (MAR/MDR) and instruction-fetch port
//               (PC/MBR) with variable-latency req/ack handshakes.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   c_bus        ALU/shifter result, loaded into registers selected by write_c
//   write_c      register load mask (bit 3 / MBR ignored)
//   enable_b     encoded B-bus select (NREG = MBRU, above that = 0)
//   b_bus        selected register value
//   h_out        H register to the A bus
//   mem_control  {write, read, fetch} command
//   busy         a memory operation is outstanding on either port
//   proto_err    one-cycle pulse after an illegal command
//   mem_*        data-port handshake (word address, write data, read data)
//   fetch_*      fetch-port handshake (byte address, fetched byte)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mic_regfile_mem #(
    parameter int NBITS = 32,
    parameter int NREG  = 10,
    parameter int BSEL  = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NBITS-1:0]  c_bus,
    input  logic [NREG-1:0]   write_c,
    input  logic [BSEL-1:0]   enable_b,
    output logic [NBITS-1:0]  b_bus,
    output logic [NBITS-1:0]  h_out,
    input  logic [2:0]        mem_control,
    output logic              busy,
    output logic              proto_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [NBITS-1:0]  mem_addr,
    output logic [NBITS-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [NBITS-1:0]  mem_rdata,
    output logic              fetch_req,
    output logic [NBITS-1:0]  fetch_addr,
    input  logic              fetch_ack,
    input  logic [7:0]        fetch_rdata
);

    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_MBR = 3;
    localparam int C_H   = 9;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } d_state_t;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } f_state_t;

    // MBR lives in its own 8-bit register; slot 3 of r_regs is never loaded.
    logic [NBITS-1:0] r_regs [NREG];
    logic [7:0]       r_mbr;

    d_state_t r_d_state, w_d_next;
    f_state_t r_f_state, w_f_next;

    logic             r_mem_we;
    logic [NBITS-1:0] r_mem_addr;
    logic [NBITS-1:0] r_mem_wdata;
    logic [NBITS-1:0] r_fetch_addr;
    logic             r_proto_err;

    logic             w_rd, w_wr, w_fetch;
    logic             w_data_start, w_data_err;
    logic             w_fetch_start, w_fetch_err;
    logic             w_rd_done, w_fetch_done;
    logic [NBITS-1:0] w_mar_post, w_mdr_post, w_pc_post;
    logic [NBITS-1:0] w_mbr_sext, w_mbr_zext;
    logic [NBITS-1:0] w_b_bus;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign w_wr    = mem_control[2];
    assign w_rd    = mem_control[1];
    assign w_fetch = mem_control[0];

    // A data command is only accepted while the port is idle; busy is high
    // throughout the ack cycle, so a command there is rejected as well.
    assign w_data_start  = (w_rd ^ w_wr) && (r_d_state == D_IDLE);
    assign w_data_err    = (w_rd && w_wr) || ((w_rd || w_wr) && (r_d_state == D_WAIT));
    assign w_fetch_start = w_fetch && (r_f_state == F_IDLE);
    assign w_fetch_err   = w_fetch && (r_f_state == F_WAIT);

    assign w_rd_done    = (r_d_state == D_WAIT) && mem_ack && !r_mem_we;
    assign w_fetch_done = (r_f_state == F_WAIT) && fetch_ack;

    // Values the address/data registers will hold after this edge, so a
    // command issued together with a C-bus load uses the new value.
    assign w_mar_post = write_c[C_MAR] ? c_bus : r_regs[C_MAR];
    assign w_mdr_post = write_c[C_MDR] ? c_bus : r_regs[C_MDR];
    assign w_pc_post  = write_c[C_PC]  ? c_bus : r_regs[C_PC];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_mbr <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i != C_MBR && write_c[i]) begin
                    r_regs[i] <= c_bus;
                end
            end
            // Later assignment wins: memory data overrides a C-bus MDR load.
            if (w_rd_done) begin
                r_regs[C_MDR] <= mem_rdata;
            end
            if (w_fetch_done) begin
                r_mbr <= fetch_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port state machines
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_state <= D_IDLE;
            r_f_state <= F_IDLE;
        end else begin
            r_d_state <= w_d_next;
            r_f_state <= w_f_next;
        end
    end

    always_comb begin
        w_d_next = r_d_state;
        case (r_d_state)
            D_IDLE:  if (w_data_start) w_d_next = D_WAIT;
            D_WAIT:  if (mem_ack)      w_d_next = D_IDLE;
            default: w_d_next = D_IDLE;
        endcase
    end

    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_IDLE:  if (w_fetch_start) w_f_next = F_WAIT;
            F_WAIT:  if (fetch_ack)     w_f_next = F_IDLE;
            default: w_f_next = F_IDLE;
        endcase
    end

    // Address/data are captured only on command acceptance, so C-bus
    // loads while waiting cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fetch_addr <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_data_start) begin
                r_mem_addr  <= w_mar_post;
                r_mem_wdata <= w_mdr_post;
                r_mem_we    <= w_wr;
            end
            if (w_fetch_start) begin
                r_fetch_addr <= w_pc_post;
            end
            r_proto_err <= w_data_err || w_fetch_err;
        end
    end

    // ------------------------------------------------------------------
    // B bus
    // ------------------------------------------------------------------
    assign w_mbr_sext = {{(NBITS-8){r_mbr[7]}}, r_mbr};
    assign w_mbr_zext = {{(NBITS-8){1'b0}}, r_mbr};

    always_comb begin
        w_b_bus = '0;
        for (int i = 0; i < NREG; i++) begin
            if (enable_b == BSEL'(i)) begin
                w_b_bus = (i == C_MBR) ? w_mbr_sext : r_regs[i];
            end
        end
        if (enable_b == BSEL'(NREG)) begin
            w_b_bus = w_mbr_zext;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign b_bus      = w_b_bus;
    assign h_out      = r_regs[C_H];
    assign mem_req    = (r_d_state == D_WAIT);
    assign fetch_req  = (r_f_state == F_WAIT);
    assign busy       = (r_d_state == D_WAIT) || (r_f_state == F_WAIT);
    assign proto_err  = r_proto_err;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign fetch_addr = r_fetch_addr;

endmodule
`default_nettype wire
